// File: rtl/p21_game_pkg.sv
// Shared definitions for the runner game controller: state encoding, score width, default timing.
package p21_game_pkg;

  typedef enum logic [1:0] {
    ATTRACT = 2'd0,
    RUN     = 2'd1,
    DEAD    = 2'd2
  } state_t;

  localparam int BCD_W = 16;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_SCORE_DIV       = 6;
  localparam int DEF_DEAD_HOLD       = 60;

endpackage

// File: rtl/p21_debounce.sv
// Button synchronizer and debouncer; press lands two sync clocks plus DEBOUNCE_CYCLES after a stable edge.
// No backpressure: level and press are free-running registered outputs.
module p21_debounce
  import p21_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      // Any sample that agrees with the accepted level restarts the run.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/p21_gamectrl.sv
// Runner game controller (ATTRACT/RUN/DEAD, BCD score); outputs registered, one clock after inputs.
// No backpressure. Define P21_HISCORE_EN to keep a high-score register, otherwise hiscore is 0000.
module p21_gamectrl
  import p21_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SCORE_DIV       = DEF_SCORE_DIV,
  parameter int DEAD_HOLD       = DEF_DEAD_HOLD
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             btn_jump,
  input  logic             frame_tick,
  input  logic             collision,
  output logic             halt,
  output logic             game_over,
  output logic             jump,
  output logic [BCD_W-1:0] score,
  output logic [BCD_W-1:0] hiscore
);

  localparam int FW = $clog2(SCORE_DIV + 1);
  localparam int HW = $clog2(DEAD_HOLD + 1);
  localparam logic [FW-1:0]    FRAME_LAST = FW'(SCORE_DIV - 1);
  localparam logic [HW-1:0]    HOLD_MAX   = HW'(DEAD_HOLD);
  localparam logic [BCD_W-1:0] SCORE_MAX  = 16'h9999;

  state_t           state, state_nx;
  logic [FW-1:0]    frame_cnt, frame_nx;
  logic [HW-1:0]    hold_cnt, hold_nx;
  logic [BCD_W-1:0] score_nx, score_inc;
  logic             jump_nx, carry;
  logic             btn_level, btn_press, start;

  p21_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (sys_rst_n),
    .btn   (btn_jump),
    .level (btn_level),
    .press (btn_press)
  );

  assign start = btn_press & btn_level;

  always_comb begin
    state_nx  = state;
    score_nx  = score;
    frame_nx  = frame_cnt;
    hold_nx   = hold_cnt;
    jump_nx   = 1'b0;
    score_inc = score;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (score[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end

    case (state)
      ATTRACT: begin
        if (start) begin
          state_nx = RUN;
          score_nx = '0;
          frame_nx = '0;
        end
      end
      RUN: begin
        // A collision wins over everything else arriving in the same clock.
        if (collision) begin
          state_nx = DEAD;
          hold_nx  = '0;
        end else begin
          jump_nx = start;
          if (frame_tick) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_nx = '0;
              if (score != SCORE_MAX) score_nx = score_inc;
            end else begin
              frame_nx = frame_cnt + FW'(1);
            end
          end
        end
      end
      DEAD: begin
        if (start && hold_cnt == HOLD_MAX) begin
          state_nx = RUN;
          score_nx = '0;
          frame_nx = '0;
        end else if (frame_tick && hold_cnt != HOLD_MAX) begin
          hold_nx = hold_cnt + HW'(1);
        end
      end
      default: state_nx = ATTRACT;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ATTRACT;
      frame_cnt <= '0;
      hold_cnt  <= '0;
      score     <= '0;
      jump      <= 1'b0;
      halt      <= 1'b1;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      frame_cnt <= frame_nx;
      hold_cnt  <= hold_nx;
      score     <= score_nx;
      jump      <= jump_nx;
      halt      <= (state_nx != RUN);
      game_over <= (state_nx == DEAD);
    end
  end

`ifdef P21_HISCORE_EN
  // BCD digits order the same way as binary, so a plain magnitude compare works.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hiscore <= '0;
    end else if (state == RUN && collision && score > hiscore) begin
      hiscore <= score;
    end
  end
`else
  assign hiscore = '0;
`endif

endmodule

// File: tb/tb_p21_gamectrl.sv
// Bench for p21_gamectrl with short debounce/divide/hold settings; score changes are scoreboarded.
module tb_p21_gamectrl;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        btn_jump = 1'b0;
  logic        frame_tick = 1'b0;
  logic        collision = 1'b0;
  logic        halt, game_over, jump;
  logic [15:0] score, hiscore;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] prev_score = 16'h0000;
  logic [15:0] popped;
  int          exp_score = 0;
  int          exp_frame = 0;
  int          exp_hi_int = 0;
  bit          exp_run = 1'b0;
  int          jump_cnt = 0;
  int          press_cnt = 0;

  p21_gamectrl #(
    .DEBOUNCE_CYCLES(4),
    .SCORE_DIV      (2),
    .DEAD_HOLD      (3)
  ) u_dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .btn_jump   (btn_jump),
    .frame_tick (frame_tick),
    .collision  (collision),
    .halt       (halt),
    .game_over  (game_over),
    .jump       (jump),
    .score      (score),
    .hiscore    (hiscore)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] hi_exp();
`ifdef P21_HISCORE_EN
    return to_bcd(exp_hi_int);
`else
    return 16'h0000;
`endif
  endfunction

  // Scoreboard monitor: every observed score change must match the next queued expectation.
  always @(negedge clk) begin
    if (score !== prev_score) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL score_change_unexpected: got %h, no change expected", score);
      end else begin
        popped = exp_q.pop_front();
        if (score !== popped) begin
          miscompares++;
          $display("FAIL score_sequence: got %h, expected %h", score, popped);
        end
      end
      prev_score = score;
    end
    if (jump === 1'b1) jump_cnt++;
    if (u_dut.u_debounce.press === 1'b1) press_cnt++;
  end

  task automatic set_exp(input int v);
    if (v != exp_score) exp_q.push_back(to_bcd(v));
    exp_score = v;
  endtask

  task automatic clocks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      if (exp_run) begin
        exp_frame++;
        if (exp_frame == 2) begin
          exp_frame = 0;
          if (exp_score < 9999) set_exp(exp_score + 1);
        end
      end
    end
    frame_tick = 1'b0;
  endtask

  task automatic press_btn(output int p_at, output int j_at);
    p_at = -1;
    j_at = -1;
    btn_jump = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) btn_jump = 1'b0;
      @(posedge clk);
      #1;
      if (u_dut.u_debounce.press === 1'b1 && p_at < 0) p_at = i;
      if (jump === 1'b1 && j_at < 0) j_at = i;
    end
  endtask

  task automatic test_reset();
    #1 sys_rst_n = 1'b0;
    #1;
    vectors++;
    if ({halt, game_over, jump} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_flags: got halt/go/jump=%b, expected 100", {halt, game_over, jump});
    end
    vectors++;
    if (score !== 16'h0000 || hiscore !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_scores: got %h/%h, expected 0000/0000", score, hiscore);
    end
    clocks(2);
    sys_rst_n = 1'b1;
    clocks(20);
    vectors++;
    if ({halt, game_over, jump} !== 3'b100 || score !== 16'h0000) begin
      miscompares++;
      $display("FAIL attract_idle: got halt/go/jump=%b score=%h, expected 100 0000",
               {halt, game_over, jump}, score);
    end
  endtask

  task automatic test_debounce_start();
    int p0;
    p0 = press_cnt;
    for (int i = 0; i < 12; i++) begin
      btn_jump = (i % 3 == 2) ? 1'b0 : 1'b1;
      clocks(1);
    end
    vectors++;
    if (halt !== 1'b1 || press_cnt != p0) begin
      miscompares++;
      $display("FAIL bounce_rejected: got halt=%b presses=%0d, expected 1 0", halt, press_cnt - p0);
    end
    btn_jump = 1'b1;
    exp_run = 1'b1;
    exp_frame = 0;
    set_exp(0);
    clocks(10);
    btn_jump = 1'b0;
    clocks(10);
    vectors++;
    if (press_cnt - p0 != 1) begin
      miscompares++;
      $display("FAIL single_press: got %0d presses, expected 1", press_cnt - p0);
    end
    vectors++;
    if ({halt, game_over, jump} !== 3'b000 || score !== 16'h0000) begin
      miscompares++;
      $display("FAIL start_run: got halt/go/jump=%b score=%h, expected 000 0000",
               {halt, game_over, jump}, score);
    end
  endtask

  task automatic test_jump();
    int p_at, j_at, j0;
    j0 = jump_cnt;
    press_btn(p_at, j_at);
    vectors++;
    if (p_at < 0 || j_at != p_at + 1) begin
      miscompares++;
      $display("FAIL jump_latency: got press@%0d jump@%0d, expected jump one clock after press",
               p_at, j_at);
    end
    vectors++;
    if (jump_cnt - j0 != 1 || halt !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_count: got %0d jumps halt=%b, expected 1 0", jump_cnt - j0, halt);
    end
  endtask

  task automatic test_score_count();
    tick(20);
    vectors++;
    if (score !== 16'h0010) begin
      miscompares++;
      $display("FAIL score_20_ticks: got %h, expected 0010", score);
    end
    tick(178);
    vectors++;
    if (score !== 16'h0099) begin
      miscompares++;
      $display("FAIL score_0099: got %h, expected 0099", score);
    end
    tick(2);
    vectors++;
    if (score !== 16'h0100) begin
      miscompares++;
      $display("FAIL score_carry_0100: got %h, expected 0100", score);
    end
  endtask

  task automatic test_collision();
    int j0;
    tick(1);
    j0 = jump_cnt;
    btn_jump = 1'b1;
    clocks(6);
    vectors++;
    if (u_dut.u_debounce.press !== 1'b1) begin
      miscompares++;
      $display("FAIL collide_press_align: got press=%b, expected 1", u_dut.u_debounce.press);
    end
    collision = 1'b1;
    frame_tick = 1'b1;
    exp_run = 1'b0;
    if (exp_score > exp_hi_int) exp_hi_int = exp_score;
    clocks(1);
    collision = 1'b0;
    frame_tick = 1'b0;
    vectors++;
    if ({halt, game_over, jump} !== 3'b110 || score !== 16'h0100) begin
      miscompares++;
      $display("FAIL collide_dead: got halt/go/jump=%b score=%h, expected 110 0100",
               {halt, game_over, jump}, score);
    end
    vectors++;
    if (hiscore !== hi_exp()) begin
      miscompares++;
      $display("FAIL hiscore_on_death: got %h, expected %h", hiscore, hi_exp());
    end
    clocks(2);
    btn_jump = 1'b0;
    clocks(10);
    vectors++;
    if (jump_cnt != j0) begin
      miscompares++;
      $display("FAIL collide_no_jump: got %0d jumps, expected 0", jump_cnt - j0);
    end
  endtask

  task automatic test_dead_hold();
    int p_at, j_at;
    tick(2);
    collision = 1'b1;
    press_btn(p_at, j_at);
    collision = 1'b0;
    vectors++;
    if (p_at < 0 || game_over !== 1'b1 || halt !== 1'b1 || score !== 16'h0100) begin
      miscompares++;
      $display("FAIL dead_hold_ignore: got press@%0d go=%b halt=%b score=%h, expected press go=1 halt=1 0100",
               p_at, game_over, halt, score);
    end
    tick(1);
    set_exp(0);
    exp_run = 1'b1;
    exp_frame = 0;
    press_btn(p_at, j_at);
    vectors++;
    if ({halt, game_over, jump} !== 3'b000 || score !== 16'h0000) begin
      miscompares++;
      $display("FAIL dead_restart: got halt/go/jump=%b score=%h, expected 000 0000",
               {halt, game_over, jump}, score);
    end
    vectors++;
    if (hiscore !== hi_exp()) begin
      miscompares++;
      $display("FAIL hiscore_persist: got %h, expected %h", hiscore, hi_exp());
    end
  endtask

  task automatic test_saturate();
    tick(19998);
    vectors++;
    if (score !== 16'h9999) begin
      miscompares++;
      $display("FAIL score_9999: got %h, expected 9999", score);
    end
    tick(6);
    vectors++;
    if (score !== 16'h9999) begin
      miscompares++;
      $display("FAIL score_saturate: got %h, expected 9999", score);
    end
  endtask

  task automatic test_async_reset();
    int p0, p_at, j_at;
    btn_jump = 1'b1;
    clocks(3);
    @(posedge clk);
    #3;
    set_exp(0);
    exp_hi_int = 0;
    exp_run = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    vectors++;
    if ({halt, game_over, jump} !== 3'b100 || score !== 16'h0000 || hiscore !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_reset: got halt/go/jump=%b score=%h hi=%h, expected 100 0000 0000",
               {halt, game_over, jump}, score, hiscore);
    end
    btn_jump = 1'b0;
    @(posedge clk);
    #3;
    sys_rst_n = 1'b1;
    p0 = press_cnt;
    clocks(15);
    vectors++;
    if (halt !== 1'b1 || press_cnt != p0) begin
      miscompares++;
      $display("FAIL reset_discard: got halt=%b presses=%0d, expected 1 0", halt, press_cnt - p0);
    end
    exp_run = 1'b1;
    exp_frame = 0;
    press_btn(p_at, j_at);
    tick(2);
    vectors++;
    if (halt !== 1'b0 || score !== 16'h0001) begin
      miscompares++;
      $display("FAIL restart_after_reset: got halt=%b score=%h, expected 0 0001", halt, score);
    end
    clocks(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_debounce_start();
    test_jump();
    test_score_count();
    test_collision();
    test_dead_hold();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/p21_gamectrl.md
P21_GAMECTRL -- requirements
Module: p21_gamectrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning clocks of stable synchronized button level needed to accept a change.
REQ-002 SHALL have parameter SCORE_DIV, default 6, meaning frame_tick pulses per score increment.
REQ-003 SHALL have parameter DEAD_HOLD, default 60, meaning frame_tick pulses in DEAD before a restart is accepted.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port btn_jump, input, 1, raw asynchronous player button, active-high.
REQ-007 SHALL have port frame_tick, input, 1, one-clock pulse per video frame.
REQ-008 SHALL have port collision, input, 1, synchronous level, high while dino overlaps an obstacle.
REQ-009 SHALL have port halt, output, 1, freezes sprite animation and scrolling when high.
REQ-010 SHALL have port game_over, output, 1, high only in DEAD.
REQ-011 SHALL have port jump, output, 1, one-clock jump request to the dino physics block.
REQ-012 SHALL have port score, output, 16, four BCD digits, MSD in [15:12].
REQ-013 SHALL have port hiscore, output, 16, four BCD digits.

Function
REQ-014 SHALL synchronize btn_jump through two flops before any other use.
REQ-015 SHALL update debounced level only after synchronized input differs from it for DEBOUNCE_CYCLES consecutive clocks; any bounce restarts the count.
REQ-016 SHALL generate press, a one-clock pulse on each debounced 0->1 transition.
REQ-017 SHALL implement states ATTRACT, RUN, DEAD; halt = 1 in ATTRACT and DEAD, 0 in RUN, all outputs registered.
REQ-018 ATTRACT: press -> RUN on next clock, score cleared to 0000.
REQ-019 RUN: jump = press, registered (one clock after press); jump is 0 in every other state.
REQ-020 RUN: frame counter counts frame_tick; on reaching SCORE_DIV it resets to 0 and score increments by 1 in BCD with digit carry; score saturates at 9999.
REQ-021 RUN: collision high -> DEAD on next clock; same-cycle score increment and jump are suppressed.
REQ-022 DEAD: hold counter cleared on entry, counts frame_tick, saturates at DEAD_HOLD; press ignored while hold < DEAD_HOLD.
REQ-023 DEAD with hold = DEAD_HOLD: press -> RUN, score and frame counter cleared; collision level irrelevant outside RUN.
REQ-024 score SHALL hold its value in DEAD and ATTRACT until cleared by a start.

Reset
REQ-025 Assertion of sys_rst_n low SHALL immediately force: state ATTRACT, halt 1, game_over 0, jump 0, score 0000, hiscore 0000, all counters 0, debounced level 0.
REQ-026 Reset mid-game SHALL discard any in-flight debounce, frame or hold count; release is synchronous to clk via the existing reset synchronizer upstream.

Configuration
REQ-027 With P21_HISCORE_EN defined, hiscore SHALL load score on the clock entering DEAD when score > hiscore (BCD compare), and persists across restarts until reset.
REQ-028 Without P21_HISCORE_EN, hiscore SHALL be constant 0000 and no hiscore register or comparator is synthesized.

Structure
REQ-029 Shared package p21_game_pkg SHALL hold the state encoding (ATTRACT=2'd0, RUN=2'd1, DEAD=2'd2), BCD width constant (16) and the default parameter values.
REQ-030 Button synchronizer plus debouncer SHALL be sub-module p21_debounce (outputs level and press); BCD increment is inline.

Verification (bench: DEBOUNCE_CYCLES=4, SCORE_DIV=2, DEAD_HOLD=3)
REQ-031 Reset, no stimulus -> halt=1, game_over=0, score=0000, state ATTRACT held indefinitely.
REQ-032 btn_jump high with 1-clock glitches every 3 clocks, then stable 10 clocks -> exactly one press, ATTRACT->RUN, halt=0.
REQ-033 In RUN, 20 frame_ticks -> score=0010; preload path to 0099 then 2 ticks -> 0100; at 9999 further ticks -> stays 9999.
REQ-034 RUN, collision and press in same clock with frame_tick completing a divide -> DEAD next clock, game_over=1, jump never asserted, score unchanged.
REQ-035 DEAD, press after 2 frame_ticks -> stays DEAD; press after 3rd -> RUN, score=0000; with P21_HISCORE_EN hiscore equals prior score, without it 0000.
REQ-036 sys_rst_n low mid-RUN for one clock, asynchronous to clk -> outputs reset immediately, ATTRACT after release.
